// File: rtl/deser_pkg.sv
// Shared types and constants for the serial-in/parallel-out receiver.
package deser_pkg;

    // State of the output holding register.
    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } deser_state_t;

    localparam int W_DEFAULT = 8;

endpackage

// File: rtl/sipo_deser_bit_counter.sv
// Counts received bits of the current partial word and wraps after the last bit.
module bit_counter #(
    parameter  int w  = deser_pkg::W_DEFAULT,
    localparam int CW = $clog2(w)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          inc,
    output logic [CW-1:0] count,
    output logic          last
);

    logic [CW-1:0] count_d, count_q;

    // Next count: clear wins, otherwise advance and wrap to 0 past w-1.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc) begin
            count_d = last ? '0 : count_q + CW'(1);
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) count_q <= '0;
        else     count_q <= count_d;
    end

    assign count = count_q;
    assign last  = (count_q == CW'(w - 1));

endmodule

// File: rtl/sipo_deser.sv
// Serial-in/parallel-out receiver: rebuilds LSB-first words from a bit strobe
// stream and holds each completed word behind a valid/ready handshake.
module sipo_deser
    import deser_pkg::*;
#(
    parameter  int w  = W_DEFAULT,
    localparam int CW = $clog2(w)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          sh,
    input  logic          b_in,
    input  logic          clr,
    input  logic          out_ready,
    output logic [w-1:0]  data_out,
    output logic          out_valid,
    output logic [CW-1:0] bit_cnt,
    output logic          ovr
);

    logic [w-1:0] sr_d, sr_q;
    logic [w-1:0] data_d, data_q;
    logic         ovr_d, ovr_q;
    deser_state_t state_d, state_q;

    logic         last;
    logic         done;
    logic [w-1:0] word;

    bit_counter #(.w(w)) u_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr),
        .inc   (sh),
        .count (bit_cnt),
        .last  (last)
    );

    // A word completes on the strobe carrying its final bit; clr discards that bit.
    assign done = sh && last && !clr;
    assign word = {b_in, sr_q[w-1:1]};

    // Shift register: bits enter at the MSB so the first bit lands in bit 0.
    // The completing bit goes straight into the holding register, so sr is left
    // alone on that edge; the next word overwrites every bit before it is used.
    always_comb begin
        sr_d = sr_q;
        if (clr) begin
            sr_d = '0;
        end else if (sh && !last) begin
            sr_d = {b_in, sr_q[w-1:1]};
        end
    end

    // Holding-register FSM: load, transfer, back-to-back reload and overrun.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        ovr_d   = clr ? 1'b0 : ovr_q;
        case (state_q)
            EMPTY: begin
                if (done) begin
                    data_d  = word;
                    state_d = FULL;
                end
            end
            FULL: begin
                if (out_ready && done) begin
                    data_d = word;
                end else if (out_ready) begin
                    state_d = EMPTY;
                end else if (done) begin
                    ovr_d = 1'b1;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            sr_q    <= '0;
            data_q  <= '0;
            ovr_q   <= 1'b0;
            state_q <= EMPTY;
        end else begin
            sr_q    <= sr_d;
            data_q  <= data_d;
            ovr_q   <= ovr_d;
            state_q <= state_d;
        end
    end

    assign data_out  = data_q;
    assign out_valid = (state_q == FULL);
    assign ovr       = ovr_q;

endmodule

// File: tb/tb_sipo_deser.sv
// Directed test of the serial-in/parallel-out receiver at w=8.
module tb_sipo_deser;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       sh = 1'b0;
    logic       b_in = 1'b0;
    logic       clr = 1'b0;
    logic       out_ready = 1'b0;
    logic [7:0] data_out;
    logic       out_valid;
    logic [2:0] bit_cnt;
    logic       ovr;

    int checks = 0;
    int errors = 0;

    sipo_deser #(.w(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .sh        (sh),
        .b_in      (b_in),
        .clr       (clr),
        .out_ready (out_ready),
        .data_out  (data_out),
        .out_valid (out_valid),
        .bit_cnt   (bit_cnt),
        .ovr       (ovr)
    );

    always #5 clk = ~clk;

    // One clock edge; outputs are read 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        sh = 1'b1; b_in = b;
        step();
        sh = 1'b0; b_in = 1'b0;
    endtask

    task automatic send_word(input logic [7:0] v);
        for (int i = 0; i < 8; i++) send_bit(v[i]);
    endtask

    task automatic test_reset();
        rst = 1'b1; sh = 1'b1; b_in = 1'b1; out_ready = 1'b1;
        step(); step();
        rst = 1'b0; sh = 1'b0; b_in = 1'b0;
        checks++;
        if ({data_out, out_valid, bit_cnt, ovr} !== 13'h0) begin
            errors++;
            $display("FAIL reset: got data=%h vld=%b cnt=%0d ovr=%b, want all 0", data_out, out_valid, bit_cnt, ovr);
        end
    endtask

    task automatic test_basic();
        logic [7:0] bits;
        bits = 8'b1010_0101;
        out_ready = 1'b1;
        send_word(bits);
        checks++;
        if (out_valid !== 1'b1 || data_out !== 8'hA5 || bit_cnt !== 3'd0 || ovr !== 1'b0) begin
            errors++;
            $display("FAIL basic_word: got vld=%b data=%h cnt=%0d ovr=%b, want 1 a5 0 0", out_valid, data_out, bit_cnt, ovr);
        end
        step();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_one_cycle: got vld=%b, want 0", out_valid);
        end
    endtask

    task automatic test_gaps();
        logic [7:0] v;
        v = 8'hA5;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            send_bit(v[i]);
            if (i == 2) begin
                checks++;
                if (bit_cnt !== 3'd3) begin
                    errors++;
                    $display("FAIL gap_cnt: got %0d, want 3", bit_cnt);
                end
            end
            if (i < 7) begin
                for (int g = 0; g <= (i % 3); g++) step();
                if (i == 2) begin
                    checks++;
                    if (bit_cnt !== 3'd3) begin
                        errors++;
                        $display("FAIL gap_hold: got %0d, want 3", bit_cnt);
                    end
                end
            end
        end
        checks++;
        if (out_valid !== 1'b1 || data_out !== 8'hA5) begin
            errors++;
            $display("FAIL gap_word: got vld=%b data=%h, want 1 a5", out_valid, data_out);
        end
        step();
    endtask

    task automatic test_overrun();
        out_ready = 1'b0;
        send_word(8'h3C);
        checks++;
        if (out_valid !== 1'b1 || data_out !== 8'h3C || ovr !== 1'b0) begin
            errors++;
            $display("FAIL ovr_first: got vld=%b data=%h ovr=%b, want 1 3c 0", out_valid, data_out, ovr);
        end
        send_word(8'h81);
        checks++;
        if (out_valid !== 1'b1 || data_out !== 8'h3C || ovr !== 1'b1) begin
            errors++;
            $display("FAIL ovr_drop: got vld=%b data=%h ovr=%b, want 1 3c 1", out_valid, data_out, ovr);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || ovr !== 1'b1) begin
            errors++;
            $display("FAIL ovr_sticky: got vld=%b ovr=%b, want 0 1", out_valid, ovr);
        end
        clr = 1'b1;
        step();
        clr = 1'b0;
        checks++;
        if (ovr !== 1'b0) begin
            errors++;
            $display("FAIL ovr_clr: got %b, want 0", ovr);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] s;
        int bubbles;
        s = 16'hFF01;
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            send_bit(s[i]);
            if (i == 7) begin
                checks++;
                if (out_valid !== 1'b1 || data_out !== 8'h01) begin
                    errors++;
                    $display("FAIL b2b_first: got vld=%b data=%h, want 1 01", out_valid, data_out);
                end
            end
        end
        checks++;
        if (out_valid !== 1'b1 || data_out !== 8'hFF || ovr !== 1'b0) begin
            errors++;
            $display("FAIL b2b_second: got vld=%b data=%h ovr=%b, want 1 ff 0", out_valid, data_out, ovr);
        end
        step();
        // Zero-bubble run: consumer only accepts on the completion edge.
        out_ready = 1'b0;
        send_word(8'h12);
        bubbles = 0;
        s = 16'h5634;
        for (int i = 0; i < 16; i++) begin
            out_ready = (i % 8 == 7);
            send_bit(s[i]);
            if (out_valid !== 1'b1) bubbles++;
            if (i == 7) begin
                checks++;
                if (data_out !== 8'h34) begin
                    errors++;
                    $display("FAIL stream_w1: got %h, want 34", data_out);
                end
            end
        end
        out_ready = 1'b0;
        checks++;
        if (bubbles != 0 || data_out !== 8'h56 || ovr !== 1'b0) begin
            errors++;
            $display("FAIL stream_nobubble: got bubbles=%0d data=%h ovr=%b, want 0 56 0", bubbles, data_out, ovr);
        end
        out_ready = 1'b1;
        step();
    endtask

    task automatic test_clr();
        out_ready = 1'b1;
        send_bit(1'b1); send_bit(1'b1); send_bit(1'b1);
        clr = 1'b1; sh = 1'b1; b_in = 1'b1;
        step();
        clr = 1'b0; sh = 1'b0; b_in = 1'b0;
        checks++;
        if (bit_cnt !== 3'd0) begin
            errors++;
            $display("FAIL clr_cnt: got %0d, want 0", bit_cnt);
        end
        send_word(8'h5A);
        checks++;
        if (out_valid !== 1'b1 || data_out !== 8'h5A) begin
            errors++;
            $display("FAIL clr_word: got vld=%b data=%h, want 1 5a", out_valid, data_out);
        end
        step();
    endtask

    task automatic test_reset_midword();
        out_ready = 1'b0;
        send_word(8'h11);
        send_word(8'h22);
        for (int i = 0; i < 5; i++) send_bit(1'b1);
        checks++;
        if (out_valid !== 1'b1 || ovr !== 1'b1 || bit_cnt !== 3'd5) begin
            errors++;
            $display("FAIL rst_setup: got vld=%b ovr=%b cnt=%0d, want 1 1 5", out_valid, ovr, bit_cnt);
        end
        rst = 1'b1; sh = 1'b1; b_in = 1'b1; out_ready = 1'b1;
        step();
        rst = 1'b0; sh = 1'b0; b_in = 1'b0; out_ready = 1'b0;
        checks++;
        if ({data_out, out_valid, bit_cnt, ovr} !== 13'h0) begin
            errors++;
            $display("FAIL rst_mid: got data=%h vld=%b cnt=%0d ovr=%b, want all 0", data_out, out_valid, bit_cnt, ovr);
        end
        send_word(8'hC3);
        checks++;
        if (out_valid !== 1'b1 || data_out !== 8'hC3 || ovr !== 1'b0) begin
            errors++;
            $display("FAIL rst_clean: got vld=%b data=%h ovr=%b, want 1 c3 0", out_valid, data_out, ovr);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_gaps();
        test_overrun();
        test_back_to_back();
        test_clr();
        test_reset_midword();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
